// File: rtl/bpu_gshare.sv
// Gshare branch predictor: BHT with 2-bit counters, global history and a circular return stack.
// Define BPU_GSHARE_EN to XOR the global history into the BHT index; otherwise indexing uses PC bits only.
module bpu_gshare #(
  parameter int BHT_DEPTH = 256,
  parameter int RAS_DEPTH = 8,
  parameter int GHR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_wr,
  input  logic             if_flush,
  input  logic [31:0]      preif_pc,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic [1:0]       ex_type,
  input  logic             ex_taken,
  input  logic             ex_hit,
  input  logic             ex_mispred,
  input  logic [1:0]       ex_count,
  input  logic [GHR_W-1:0] ex_ghr,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic             pred_hit,
  output logic [31:0]      pred_target,
  output logic [1:0]       pred_type,
  output logic [1:0]       pred_count,
  output logic [GHR_W-1:0] pred_ghr
);

  localparam int IDX    = $clog2(BHT_DEPTH);
  localparam int TAG_W  = 30 - IDX;
  localparam int RAS_AW = $clog2(RAS_DEPTH);
  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_IMME = 2'b01;
  localparam logic [1:0] T_CALL = 2'b10;
  localparam logic [1:0] T_RETN = 2'b11;
  localparam logic [RAS_AW:0] RAS_FULL = (RAS_AW + 1)'(RAS_DEPTH);

  logic [BHT_DEPTH-1:0] bht_valid;
  logic [TAG_W-1:0]     bht_tag    [BHT_DEPTH];
  logic [31:0]          bht_target [BHT_DEPTH];
  logic [1:0]           bht_type   [BHT_DEPTH];
  logic [1:0]           bht_count  [BHT_DEPTH];

  logic [GHR_W-1:0] ghr;
  logic [IDX-1:0]   rd_idx;
  logic [IDX-1:0]   wr_idx;
  logic             rd_hit;
  logic [1:0]       new_count;

  logic             s_valid;
  logic             s_hit;
  logic [31:0]      s_pc;
  logic [31:0]      s_target;
  logic [1:0]       s_type;
  logic [1:0]       s_count;
  logic [GHR_W-1:0] s_ghr;

  logic [31:0]       ras [RAS_DEPTH];
  logic [RAS_AW-1:0] ras_ptr;
  logic [RAS_AW:0]   ras_cnt;
  logic              push;
  logic              pop;
  logic [31:0]       ras_top;
  logic              ras_any;

`ifdef BPU_GSHARE_EN
  assign rd_idx = preif_pc[IDX+1:2] ^ IDX'(ghr);
  assign wr_idx = ex_pc[IDX+1:2] ^ IDX'(ex_ghr);

  // A resolved imme mispredict rebuilds history from its snapshot and beats the speculative shift
  always_ff @(posedge clk) begin
    if (!rst)
      ghr <= '0;
    else if (ex_valid && ex_mispred && ex_type == T_IMME)
      ghr <= {ex_ghr[GHR_W-2:0], ex_taken};
    else if (if_wr && !if_flush && rd_hit && bht_type[rd_idx] == T_IMME)
      ghr <= {ghr[GHR_W-2:0], bht_count[rd_idx][1]};
  end
`else
  logic unused_ok;
  assign unused_ok = ^{ex_ghr, ex_mispred};
  assign rd_idx = preif_pc[IDX+1:2];
  assign wr_idx = ex_pc[IDX+1:2];
  assign ghr    = '0;
`endif

  assign rd_hit = bht_valid[rd_idx] && (bht_tag[rd_idx] == preif_pc[31:IDX+2]);

  always_comb begin
    new_count = ex_taken ? 2'b10 : 2'b01;
    if (ex_hit) begin
      if (ex_taken)
        new_count = (ex_count == 2'b11) ? 2'b11 : ex_count + 2'b01;
      else
        new_count = (ex_count == 2'b00) ? 2'b00 : ex_count - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      bht_valid <= '0;
    else if (ex_valid)
      bht_valid[wr_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst && ex_valid) begin
      bht_tag[wr_idx]    <= ex_pc[31:IDX+2];
      bht_target[wr_idx] <= ex_target;
      bht_type[wr_idx]   <= ex_type;
      bht_count[wr_idx]  <= new_count;
    end
  end

  // The fetch loaded right after a valid taken prediction is the delay slot
  always_ff @(posedge clk) begin
    if (!rst || if_flush) begin
      s_valid  <= 1'b0;
      s_hit    <= 1'b0;
      s_pc     <= '0;
      s_target <= '0;
      s_type   <= T_NONE;
      s_count  <= 2'b00;
      s_ghr    <= '0;
    end else if (if_wr) begin
      s_valid  <= !(pred_valid && pred_taken);
      s_hit    <= rd_hit;
      s_pc     <= preif_pc;
      s_target <= bht_target[rd_idx];
      s_type   <= rd_hit ? bht_type[rd_idx] : T_NONE;
      s_count  <= rd_hit ? bht_count[rd_idx] : 2'b00;
      s_ghr    <= ghr;
    end
  end

  assign push = ex_valid && ex_type == T_CALL;
  assign pop  = ex_valid && ex_type == T_RETN;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (push) begin
      ras_ptr <= ras_ptr + RAS_AW'(1);
      if (ras_cnt != RAS_FULL)
        ras_cnt <= ras_cnt + 1'b1;
    end else if (pop && ras_cnt != '0) begin
      ras_ptr <= ras_ptr - RAS_AW'(1);
      ras_cnt <= ras_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push)
      ras[ras_ptr + RAS_AW'(1)] <= ex_pc + 32'd8;
  end

  assign ras_top = push ? ex_pc + 32'd8 : ras[ras_ptr];
  assign ras_any = push || ras_cnt != '0;

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = s_pc + 32'd8;
    if (s_hit) begin
      case (s_type)
        T_CALL: begin
          pred_taken  = 1'b1;
          pred_target = s_target;
        end
        T_IMME: if (s_count[1]) begin
          pred_taken  = 1'b1;
          pred_target = s_target;
        end
        T_RETN: if (ras_any) begin
          pred_taken  = 1'b1;
          pred_target = ras_top;
        end
        default: ;
      endcase
    end
  end

  assign pred_valid = s_valid;
  assign pred_hit   = s_hit;
  assign pred_type  = s_type;
  assign pred_count = s_count;
  assign pred_ghr   = s_ghr;

endmodule

// File: tb/tb_bpu_gshare.sv
// Directed bench for bpu_gshare (RAS_DEPTH=2); expected history values follow BPU_GSHARE_EN.
module tb_bpu_gshare;

  localparam logic [1:0] T_IMME = 2'b01;
  localparam logic [1:0] T_CALL = 2'b10;
  localparam logic [1:0] T_RETN = 2'b11;
`ifdef BPU_GSHARE_EN
  localparam logic [7:0] GHR_ONE   = 8'h01;
  localparam logic [7:0] GHR_AFTER = 8'hB5;
`else
  localparam logic [7:0] GHR_ONE   = 8'h00;
  localparam logic [7:0] GHR_AFTER = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_wr = 1'b0;
  logic        if_flush = 1'b0;
  logic [31:0] preif_pc = '0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_target = '0;
  logic [1:0]  ex_type = '0;
  logic        ex_taken = 1'b0;
  logic        ex_hit = 1'b0;
  logic        ex_mispred = 1'b0;
  logic [1:0]  ex_count = '0;
  logic [7:0]  ex_ghr = '0;
  logic        pred_valid;
  logic        pred_taken;
  logic        pred_hit;
  logic [31:0] pred_target;
  logic [1:0]  pred_type;
  logic [1:0]  pred_count;
  logic [7:0]  pred_ghr;

  int total = 0;
  int bad = 0;

  bpu_gshare #(.BHT_DEPTH(256), .RAS_DEPTH(2), .GHR_W(8)) dut (
    .clk(clk), .rst(rst), .if_wr(if_wr), .if_flush(if_flush), .preif_pc(preif_pc),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target), .ex_type(ex_type),
    .ex_taken(ex_taken), .ex_hit(ex_hit), .ex_mispred(ex_mispred), .ex_count(ex_count),
    .ex_ghr(ex_ghr), .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_hit(pred_hit),
    .pred_target(pred_target), .pred_type(pred_type), .pred_count(pred_count), .pred_ghr(pred_ghr)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    preif_pc = pc; if_wr = 1'b1;
    @(posedge clk); #1;
    if_wr = 1'b0; #1;
  endtask

  task automatic flush();
    if_flush = 1'b1;
    @(posedge clk); #1;
    if_flush = 1'b0; #1;
  endtask

  task automatic set_ex(input logic [31:0] pc, tgt, input logic [1:0] typ, input logic tk, ht,
                        input logic [1:0] cnt, input logic mp, input logic [7:0] gh);
    ex_valid = 1'b1; ex_pc = pc; ex_target = tgt; ex_type = typ; ex_taken = tk;
    ex_hit = ht; ex_count = cnt; ex_mispred = mp; ex_ghr = gh;
  endtask

  task automatic resolve(input logic [31:0] pc, tgt, input logic [1:0] typ, input logic tk, ht,
                         input logic [1:0] cnt, input logic mp, input logic [7:0] gh);
    set_ex(pc, tgt, typ, tk, ht, cnt, mp, gh);
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_mispred = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; preif_pc = 32'h1000; if_wr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    total++; if (pred_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%b exp=0", pred_valid); end
    total++; if (pred_hit !== 1'b0 || pred_taken !== 1'b0) begin bad++; $display("[TB] FAIL rst_hit_taken got=%b%b exp=00", pred_hit, pred_taken); end
    total++; if (pred_type !== 2'b00 || pred_count !== 2'b00) begin bad++; $display("[TB] FAIL rst_type_count got=%b/%b exp=00/00", pred_type, pred_count); end
    total++; if (pred_ghr !== 8'h00) begin bad++; $display("[TB] FAIL rst_ghr got=%h exp=00", pred_ghr); end
    total++; if (pred_target !== 32'h8) begin bad++; $display("[TB] FAIL rst_target got=%h exp=00000008", pred_target); end
    if_wr = 1'b0; rst = 1'b1;
    @(posedge clk); #2;
    total++; if (pred_valid !== 1'b0 || pred_target !== 32'h8) begin bad++; $display("[TB] FAIL post_rst got=%b/%h exp=0/00000008", pred_valid, pred_target); end
  endtask

  task automatic test_miss();
    do_reset();
    fetch(32'h1000);
    total++; if (pred_hit !== 1'b0) begin bad++; $display("[TB] FAIL miss_hit got=%b exp=0", pred_hit); end
    total++; if (pred_target !== 32'h1008) begin bad++; $display("[TB] FAIL miss_target got=%h exp=00001008", pred_target); end
    total++; if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin bad++; $display("[TB] FAIL miss_valid_taken got=%b%b exp=10", pred_valid, pred_taken); end
  endtask

  task automatic test_counter();
    do_reset();
    resolve(32'h2000, 32'h3000, T_IMME, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    fetch(32'h2000);
    total++; if (pred_hit !== 1'b1 || pred_count !== 2'b10) begin bad++; $display("[TB] FAIL train1 got=%b/%b exp=1/10", pred_hit, pred_count); end
    total++; if (pred_taken !== 1'b1 || pred_target !== 32'h3000) begin bad++; $display("[TB] FAIL train1_tgt got=%b/%h exp=1/00003000", pred_taken, pred_target); end
    flush();
    resolve(32'h2000, 32'h3000, T_IMME, 1'b1, 1'b1, 2'b10, 1'b0, 8'h01);
    fetch(32'h2000);
    total++; if (pred_count !== 2'b11 || pred_type !== T_IMME) begin bad++; $display("[TB] FAIL train2 got=%b/%b exp=11/01", pred_count, pred_type); end
    total++; if (pred_valid !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h3000) begin bad++; $display("[TB] FAIL train2_tgt got=%b%b/%h exp=11/00003000", pred_valid, pred_taken, pred_target); end
    total++; if (pred_ghr !== GHR_ONE) begin bad++; $display("[TB] FAIL train2_ghr got=%h exp=%h", pred_ghr, GHR_ONE); end
    fetch(32'h1000);
    total++; if (pred_valid !== 1'b0 || pred_hit !== 1'b0) begin bad++; $display("[TB] FAIL delay_slot got=%b/%b exp=0/0", pred_valid, pred_hit); end
    fetch(32'h1000);
    total++; if (pred_valid !== 1'b1) begin bad++; $display("[TB] FAIL after_slot got=%b exp=1", pred_valid); end
  endtask

  task automatic test_not_taken();
    do_reset();
    resolve(32'h2400, 32'h5000, T_IMME, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
    fetch(32'h2400);
    total++; if (pred_count !== 2'b01 || pred_taken !== 1'b0 || pred_target !== 32'h2408) begin bad++; $display("[TB] FAIL nt_first got=%b/%b/%h exp=01/0/00002408", pred_count, pred_taken, pred_target); end
    resolve(32'h2400, 32'h5000, T_IMME, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00);
    fetch(32'h2400);
    total++; if (pred_count !== 2'b00 || pred_valid !== 1'b1) begin bad++; $display("[TB] FAIL sat_low got=%b/%b exp=00/1", pred_count, pred_valid); end
    resolve(32'h2400, 32'h5000, T_IMME, 1'b0, 1'b1, 2'b10, 1'b0, 8'h00);
    fetch(32'h2400);
    total++; if (pred_count !== 2'b01 || pred_taken !== 1'b0) begin bad++; $display("[TB] FAIL dec got=%b/%b exp=01/0", pred_count, pred_taken); end
    resolve(32'h2400, 32'h5000, T_IMME, 1'b1, 1'b1, 2'b11, 1'b0, 8'h00);
    fetch(32'h2400);
    total++; if (pred_count !== 2'b11 || pred_taken !== 1'b1 || pred_target !== 32'h5000) begin bad++; $display("[TB] FAIL sat_high got=%b/%b/%h exp=11/1/00005000", pred_count, pred_taken, pred_target); end
  endtask

  task automatic test_ras();
    do_reset();
    resolve(32'h400, 32'h0, T_RETN, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    resolve(32'h100, 32'h800, T_CALL, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    resolve(32'h200, 32'h900, T_CALL, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    fetch(32'h400);
    total++; if (pred_hit !== 1'b1 || pred_type !== T_RETN || pred_valid !== 1'b1) begin bad++; $display("[TB] FAIL retn_hit got=%b/%b/%b exp=1/11/1", pred_hit, pred_type, pred_valid); end
    total++; if (pred_taken !== 1'b1 || pred_target !== 32'h208) begin bad++; $display("[TB] FAIL ras_top1 got=%b/%h exp=1/00000208", pred_taken, pred_target); end
    resolve(32'h400, 32'h0, T_RETN, 1'b1, 1'b1, 2'b10, 1'b0, 8'h00);
    total++; if (pred_taken !== 1'b1 || pred_target !== 32'h108) begin bad++; $display("[TB] FAIL ras_top2 got=%b/%h exp=1/00000108", pred_taken, pred_target); end
    resolve(32'h400, 32'h0, T_RETN, 1'b1, 1'b1, 2'b10, 1'b0, 8'h00);
    total++; if (pred_taken !== 1'b0 || pred_target !== 32'h408) begin bad++; $display("[TB] FAIL ras_empty got=%b/%h exp=0/00000408", pred_taken, pred_target); end
    resolve(32'h400, 32'h0, T_RETN, 1'b1, 1'b1, 2'b10, 1'b0, 8'h00);
    total++; if (pred_taken !== 1'b0 || pred_target !== 32'h408) begin bad++; $display("[TB] FAIL ras_underflow got=%b/%h exp=0/00000408", pred_taken, pred_target); end
    set_ex(32'h700, 32'hA00, T_CALL, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    #1;
    total++; if (pred_taken !== 1'b1 || pred_target !== 32'h708) begin bad++; $display("[TB] FAIL ras_fwd got=%b/%h exp=1/00000708", pred_taken, pred_target); end
    @(posedge clk); #1;
    ex_valid = 1'b0; #1;
    total++; if (pred_taken !== 1'b1 || pred_target !== 32'h708) begin bad++; $display("[TB] FAIL ras_after_fwd got=%b/%h exp=1/00000708", pred_taken, pred_target); end
    flush();
    fetch(32'h100);
    total++; if (pred_type !== T_CALL || pred_taken !== 1'b1 || pred_target !== 32'h800) begin bad++; $display("[TB] FAIL call_hit got=%b/%b/%h exp=10/1/00000800", pred_type, pred_taken, pred_target); end
  endtask

  task automatic test_ras_overflow();
    do_reset();
    resolve(32'h400, 32'h0, T_RETN, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    resolve(32'h100, 32'h800, T_CALL, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    resolve(32'h200, 32'h900, T_CALL, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    resolve(32'h300, 32'hB00, T_CALL, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    fetch(32'h400);
    total++; if (pred_target !== 32'h308) begin bad++; $display("[TB] FAIL ovf_top got=%h exp=00000308", pred_target); end
    resolve(32'h400, 32'h0, T_RETN, 1'b1, 1'b1, 2'b10, 1'b0, 8'h00);
    total++; if (pred_taken !== 1'b1 || pred_target !== 32'h208) begin bad++; $display("[TB] FAIL ovf_second got=%b/%h exp=1/00000208", pred_taken, pred_target); end
    resolve(32'h400, 32'h0, T_RETN, 1'b1, 1'b1, 2'b10, 1'b0, 8'h00);
    total++; if (pred_taken !== 1'b0 || pred_target !== 32'h408) begin bad++; $display("[TB] FAIL ovf_lost got=%b/%h exp=0/00000408", pred_taken, pred_target); end
  endtask

  task automatic test_mispredict();
    do_reset();
    resolve(32'h2000, 32'h3000, T_IMME, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    preif_pc = 32'h2000; if_wr = 1'b1;
    set_ex(32'h5000, 32'h6000, T_IMME, 1'b1, 1'b1, 2'b01, 1'b1, 8'h5A);
    @(posedge clk); #1;
    if_wr = 1'b0; ex_valid = 1'b0; ex_mispred = 1'b0; #1;
    total++; if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_ghr !== 8'h00) begin bad++; $display("[TB] FAIL mp_load got=%b/%b/%h exp=1/1/00", pred_hit, pred_taken, pred_ghr); end
    fetch(32'h1000);
    total++; if (pred_ghr !== GHR_AFTER) begin bad++; $display("[TB] FAIL mp_ghr got=%h exp=%h", pred_ghr, GHR_AFTER); end
    total++; if (pred_valid !== 1'b0) begin bad++; $display("[TB] FAIL mp_slot got=%b exp=0", pred_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    fetch(32'h1000);
    preif_pc = 32'h2000; if_wr = 1'b1; if_flush = 1'b1;
    @(posedge clk); #1;
    if_wr = 1'b0; if_flush = 1'b0; #1;
    total++; if (pred_valid !== 1'b0 || pred_hit !== 1'b0) begin bad++; $display("[TB] FAIL flush_wins got=%b/%b exp=0/0", pred_valid, pred_hit); end
    total++; if (pred_target !== 32'h8 || pred_ghr !== 8'h00) begin bad++; $display("[TB] FAIL flush_clear got=%h/%h exp=00000008/00", pred_target, pred_ghr); end
    fetch(32'h1000);
    total++; if (pred_valid !== 1'b1 || pred_target !== 32'h1008) begin bad++; $display("[TB] FAIL flush_resume got=%b/%h exp=1/00001008", pred_valid, pred_target); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    resolve(32'h2000, 32'h3000, T_IMME, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    fetch(32'h2000);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    fetch(32'h2000);
    total++; if (pred_hit !== 1'b0 || pred_target !== 32'h2008 || pred_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_reset got=%b/%h/%b exp=0/00002008/1", pred_hit, pred_target, pred_valid); end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_counter();
    test_not_taken();
    test_ras();
    test_ras_overflow();
    test_mispredict();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bpu_gshare.md
BPU_GSHARE -- requirements
Module: bpu_gshare

Interface
REQ-001 Parameter BHT_DEPTH, default 256, BHT entry count; power of 2, range 16..4096.
REQ-002 Parameter RAS_DEPTH, default 8, return stack entries; power of 2, range 2..64.
REQ-003 Parameter GHR_W, default 8, global history width; must satisfy GHR_W <= log2(BHT_DEPTH).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 if_wr  in  1  fetch advance; 0 holds the prediction stage.
REQ-007 if_flush  in  1  kills the prediction stage contents.
REQ-008 preif_pc  in  32  next fetch PC; word aligned.
REQ-009 ex_valid  in  1  a branch resolved in EXE this cycle.
REQ-010 ex_pc / ex_target  in  32 each  resolved branch PC and its actual target.
REQ-011 ex_type  in  2  00 none, 01 imme, 10 call, 11 retn.
REQ-012 ex_taken / ex_hit / ex_mispred  in  1 each  actual direction, BHT hit at predict time, misprediction.
REQ-013 ex_count  in  2  counter value at predict time.
REQ-014 ex_ghr  in  GHR_W  GHR snapshot carried with the branch.
REQ-015 pred_valid / pred_taken / pred_hit  out  1 each  prediction usable, taken, BHT hit.
REQ-016 pred_target  out  32  predicted next PC.
REQ-017 pred_type / pred_count  out  2 each  predicted type (00 on miss), counter value.
REQ-018 pred_ghr  out  GHR_W  GHR used for this prediction; the pipeline returns it as ex_ghr.

Function
REQ-019 BHT entry: valid, tag = PC[31:IDX+2], 32-bit target, 2-bit type, 2-bit counter; IDX = log2(BHT_DEPTH).
REQ-020 Read index = PC[IDX+1:2] XOR zero-extended GHR; read at preif_pc, result registered in a stage register; latency 1 cycle.
REQ-021 Stage register loads when if_wr=1; holds when if_wr=0; if_flush clears it, and if_flush wins over if_wr.
REQ-022 pred_valid=0 after a flush, and for the fetch captured immediately after a taken prediction (delay slot).
REQ-023 Hit = entry valid AND tag match; on a miss: pred_target=PC+8, pred_taken=0, pred_type=00.
REQ-024 On a hit: call -> BHT target, taken; imme -> taken if count[1]=1, else PC+8; retn -> RAS top, taken if the RAS is non-empty, else PC+8 and not taken.
REQ-025 Write on ex_valid at index ex_pc[IDX+1:2] XOR ex_ghr; a same-cycle read of the same index returns the old contents.
REQ-026 Counter update: if ex_hit, saturating +1 when taken and -1 when not, clamped to 00..11; if not ex_hit, 10 when taken, else 01.
REQ-027 Speculative GHR: on a stage load with a hit of type imme, shift in pred_taken at the LSB.
REQ-028 On ex_mispred with type imme, GHR = {ex_ghr[GHR_W-2:0], ex_taken}; this overrides the same-cycle speculative shift.
REQ-029 RAS is circular with a top pointer and a count of 0..RAS_DEPTH; resolved call pushes ex_pc+8; resolved retn pops.
REQ-030 Push when full overwrites the oldest entry; the pointer wraps and count stays at RAS_DEPTH.
REQ-031 Pop when empty leaves pointer and count unchanged.
REQ-032 A same-cycle push is forwarded to the RAS read used by the prediction.

Reset
REQ-033 rst=0 at a clock edge clears all BHT valid bits, the stage register, GHR, RAS pointer and RAS count.
REQ-034 During and after reset: pred_valid=0, pred_taken=0, pred_hit=0, pred_type=00, pred_count=00, pred_ghr=0, pred_target=8 (PC_Add8 of a zero PC).
REQ-035 Reset asserted mid-operation discards pending speculative state; the first prediction after reset is a miss.

Configuration
REQ-036 Macro BPU_GSHARE_EN defined: GHR XOR indexing and history tracking as specified above.
REQ-037 Macro BPU_GSHARE_EN undefined: index = PC bits only; GHR held at 0; pred_ghr=0; ex_ghr ignored.

Verification
REQ-038 Miss: preif_pc=0x1000 after reset -> next cycle pred_hit=0, pred_target=0x1008, pred_valid=1.
REQ-039 Counter training: imme at 0x2000 resolved taken (target 0x3000) twice -> count 10 then 11; next fetch of 0x2000 predicts taken with target 0x3000.
REQ-040 RAS: calls at 0x100 and 0x200, then retn hit -> pred_target=0x208, then 0x108; a third retn -> PC+8, not taken.
REQ-041 RAS overflow with RAS_DEPTH=2: three calls -> count=2, oldest entry lost; two pops return the newest two addresses.
REQ-042 Mispredict recovery: ex_mispred=1, ex_ghr=0x5A, ex_taken=1 with a simultaneous imme stage load -> GHR=0xB5.
REQ-043 if_flush and if_wr both 1 -> pred_valid=0 the next cycle; with BPU_GSHARE_EN undefined, pred_ghr=0 throughout.
